multdiv_issue_ctrl: RTL and testbench
=====================================

Name: multdiv_issue_ctrl

Overview:
- Sequencing stage directly upstream of the multdiv unit, sitting between the execute stage and writeback.
- Accepts one MULT/DIV issue, latches its operands, and pulses ctrl_MULT or ctrl_DIV for exactly one cycle.
- Holds the operands stable while the unit runs, stalls the pipeline, and waits for data_resultRDY.
- Presents the result, or an rstatus exception write, on a valid/ready writeback port.

Parameters:
- TIMEOUT_CYCLES, 40, BUSY cycles allowed without RDY before the op is forced to an exception.
- EXC_RD, 30, destination register for exception writes (rstatus).
- EXC_MULT_CODE, 4, rstatus value written on a mult exception.
- EXC_DIV_CODE, 5, rstatus value written on a div exception.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- issue_valid  in  1  upstream has an instruction.
- issue_mult  in  1  instruction is MULT.
- issue_div  in  1  instruction is DIV.
- issue_a  in  32  operand A / dividend.
- issue_b  in  32  operand B / divisor.
- issue_rd  in  5  destination register.
- issue_ready  out  1  controller can accept an issue.
- flush  in  1  kill the in-flight operation.
- md_operandA  out  32  to multdiv data_operandA.
- md_operandB  out  32  to multdiv data_operandB.
- md_ctrl_MULT  out  1  one-cycle start pulse, mult.
- md_ctrl_DIV  out  1  one-cycle start pulse, div.
- md_result  in  32  multdiv data_result.
- md_exception  in  1  multdiv data_exception.
- md_resultRDY  in  1  multdiv data_resultRDY.
- stall  out  1  freeze upstream stages.
- busy_rd  out  5  rd of the in-flight op (hazard detection).
- busy_rd_valid  out  1  busy_rd is meaningful.
- wb_valid  out  1  writeback request.
- wb_ready  in  1  writeback port accepts.
- wb_rd  out  5  writeback register.
- wb_data  out  32  writeback value.

Behaviour:
- States: IDLE, START, BUSY, DONE. Encoding comes from the shared package.
- Reset (reset low, asynchronous): state IDLE, operand regs 0, md_ctrl_* 0, wb_valid 0, wb_rd 0, wb_data 0, busy_rd 0, busy_rd_valid 0, timeout counter 0.
- Outputs after reset: issue_ready 1, stall 0.
- Reset is honoured mid-operation. The multdiv result from the aborted op is never written back.
- issue_ready = (state==IDLE).
- An issue is accepted at a rising edge when issue_valid & issue_ready & (issue_mult|issue_div).
- If both issue_mult and issue_div are high, mult wins.
- If neither is high, nothing is accepted and the state stays IDLE.
- On accept: latch a, b, rd and op type, then go to START.
- md_operandA and md_operandB are driven from the latch only, so they are stable from START until the next accept.
- START lasts exactly one cycle. md_ctrl_MULT or md_ctrl_DIV is high only in START, and is 0 in every other state.
- md_resultRDY is ignored in START, because it can be stale from the previous op.
- BUSY:
  - The timeout counter increments each cycle.
  - At the first edge where md_resultRDY=1, go to DONE.
  - If md_exception=0: capture wb_data=md_result and wb_rd=latched rd.
  - If md_exception=1: capture wb_rd=EXC_RD and wb_data=EXC_MULT_CODE or EXC_DIV_CODE, zero-extended.
  - If the counter reaches TIMEOUT_CYCLES with no RDY, go to DONE with the exception encoding.
- DONE:
  - wb_valid=1. wb_rd and wb_data are held stable until the handshake.
  - On wb_valid & wb_ready, go to IDLE.
  - No new issue is accepted in the same cycle as the handshake; issue_ready only rises in the following cycle.
- stall = (state!=IDLE).
- busy_rd_valid = (state!=IDLE) & no exception captured. busy_rd = latched rd.
- flush:
  - In START, BUSY or DONE, flush goes to IDLE at the next edge with no writeback. wb_valid drops that edge.
  - In START, the md_ctrl pulse still occurs. The multdiv unit is left running and its result is discarded.
  - flush in IDLE blocks any simultaneous issue; flush has priority.
- If rd is 0 with no exception, the writeback is still issued. The register file discards writes to r0.

Decomposition:
- Package multdiv_ctrl_pkg holds:
  - state encoding constants (2 bits: IDLE, START, BUSY, DONE);
  - the EXC_RD, EXC_MULT_CODE and EXC_DIV_CODE defaults;
  - the op-type bit definition.
- One natural sub-module: md_timeout_counter. It is a 6-bit counter with sync clear and enable, plus a terminal-count compare against TIMEOUT_CYCLES.

Test Plan:
- MULT a=7, b=6, rd=5, with the multdiv model raising RDY 17 cycles after the pulse.
  - Expect one md_ctrl_MULT pulse and stall high throughout.
  - Expect wb_valid with wb_rd=5, wb_data=42, then issue_ready back to 1.
- DIV a=100, b=7, rd=9, with stale RDY=1 during START.
  - Expect RDY ignored in START and md_operandA/B held at 100/7.
  - Expect final wb_rd=9, wb_data=14.
- DIV b=0, model asserts exception with RDY. Expect wb_rd=30, wb_data=5. MULT overflow case: expect wb_rd=30, wb_data=4.
- wb_ready held low for 5 cycles in DONE.
  - Expect wb_valid, wb_rd and wb_data stable, and stall=1.
  - A concurrent issue_valid is not accepted until the cycle after the handshake.
- Model never asserts RDY. Expect DONE after 40 BUSY cycles with wb_rd=30 and the op-specific code.
- flush in BUSY: IDLE next cycle and no wb_valid ever; a later RDY is ignored.
  - reset low mid-BUSY: all outputs take reset values immediately and no wb_valid follows.

Source files
------------

// File: rtl/multdiv_ctrl_pkg.sv
// ============================================================================
// Module      : multdiv_ctrl_pkg
// Description : Shared state encoding, op-type bit and exception defaults
//               for the multdiv issue controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package multdiv_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_BUSY  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  typedef enum logic {
    OP_MULT = 1'b0,
    OP_DIV  = 1'b1
  } op_t;

  localparam int          TIMEOUT_CYCLES_DEFAULT = 40;
  localparam int          TIMEOUT_CNT_W          = 6;
  localparam logic [4:0]  EXC_RD_DEFAULT         = 5'd30;
  localparam logic [31:0] EXC_MULT_CODE_DEFAULT  = 32'd4;
  localparam logic [31:0] EXC_DIV_CODE_DEFAULT   = 32'd5;

endpackage

`default_nettype wire

// File: rtl/md_timeout_counter.sv
// ============================================================================
// Module      : md_timeout_counter
// Description : 6-bit BUSY-cycle counter with sync clear/enable and a
//               terminal-count flag for the final allowed cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module md_timeout_counter
  import multdiv_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  localparam logic [TIMEOUT_CNT_W-1:0] c_one  = TIMEOUT_CNT_W'(1);
  localparam logic [TIMEOUT_CNT_W-1:0] c_last = TIMEOUT_CNT_W'(TIMEOUT_CYCLES - 1);

  logic [TIMEOUT_CNT_W-1:0] r_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + c_one;
    end
  end

  // High during the last BUSY cycle still allowed to see RDY.
  assign o_tc = (r_count == c_last);

endmodule

`default_nettype wire

// File: rtl/multdiv_issue_ctrl.sv
// ============================================================================
// Module      : multdiv_issue_ctrl
// Description : Issues one MULT/DIV to the multdiv unit, stalls while it
//               runs, and presents the result on a valid/ready writeback port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module multdiv_issue_ctrl
  import multdiv_ctrl_pkg::*;
#(
  parameter int          TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT,
  parameter logic [4:0]  EXC_RD         = EXC_RD_DEFAULT,
  parameter logic [31:0] EXC_MULT_CODE  = EXC_MULT_CODE_DEFAULT,
  parameter logic [31:0] EXC_DIV_CODE   = EXC_DIV_CODE_DEFAULT
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_issue_valid,
  input  logic        i_issue_mult,
  input  logic        i_issue_div,
  input  logic [31:0] i_issue_a,
  input  logic [31:0] i_issue_b,
  input  logic [4:0]  i_issue_rd,
  output logic        o_issue_ready,
  input  logic        i_flush,
  output logic [31:0] o_md_operandA,
  output logic [31:0] o_md_operandB,
  output logic        o_md_ctrl_MULT,
  output logic        o_md_ctrl_DIV,
  input  logic [31:0] i_md_result,
  input  logic        i_md_exception,
  input  logic        i_md_resultRDY,
  output logic        o_stall,
  output logic [4:0]  o_busy_rd,
  output logic        o_busy_rd_valid,
  output logic        o_wb_valid,
  input  logic        i_wb_ready,
  output logic [4:0]  o_wb_rd,
  output logic [31:0] o_wb_data
);

  state_t      r_state;
  op_t         r_op;
  logic [31:0] r_op_a;
  logic [31:0] r_op_b;
  logic [4:0]  r_rd;
  logic        r_exc;
  logic        r_ctrl_mult;
  logic        r_ctrl_div;
  logic        r_wb_valid;
  logic [4:0]  r_wb_rd;
  logic [31:0] r_wb_data;

  logic        w_accept;
  logic        w_tc;
  logic        w_in_busy;
  logic [31:0] w_exc_code;

  assign w_accept   = i_issue_valid & (i_issue_mult | i_issue_div);
  assign w_in_busy  = (r_state == ST_BUSY);
  assign w_exc_code = (r_op == OP_MULT) ? EXC_MULT_CODE : EXC_DIV_CODE;

  md_timeout_counter #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (!w_in_busy),
    .i_en    (w_in_busy),
    .o_tc    (w_tc)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_op        <= OP_MULT;
      r_op_a      <= '0;
      r_op_b      <= '0;
      r_rd        <= '0;
      r_exc       <= 1'b0;
      r_ctrl_mult <= 1'b0;
      r_ctrl_div  <= 1'b0;
      r_wb_valid  <= 1'b0;
      r_wb_rd     <= '0;
      r_wb_data   <= '0;
    end else begin
      r_ctrl_mult <= 1'b0;
      r_ctrl_div  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          // Flush in IDLE suppresses a simultaneous issue.
          if (!i_flush && w_accept) begin
            r_op        <= i_issue_mult ? OP_MULT : OP_DIV;
            r_op_a      <= i_issue_a;
            r_op_b      <= i_issue_b;
            r_rd        <= i_issue_rd;
            r_exc       <= 1'b0;
            r_ctrl_mult <= i_issue_mult;
            r_ctrl_div  <= !i_issue_mult;
            r_state     <= ST_START;
          end
        end
        ST_START: begin
          // RDY may still be high from the previous op; not sampled here.
          r_state <= i_flush ? ST_IDLE : ST_BUSY;
        end
        ST_BUSY: begin
          if (i_flush) begin
            r_state <= ST_IDLE;
          end else if (i_md_resultRDY && !i_md_exception) begin
            r_state    <= ST_DONE;
            r_wb_valid <= 1'b1;
            r_wb_rd    <= r_rd;
            r_wb_data  <= i_md_result;
          end else if (i_md_resultRDY || w_tc) begin
            r_state    <= ST_DONE;
            r_wb_valid <= 1'b1;
            r_exc      <= 1'b1;
            r_wb_rd    <= EXC_RD;
            r_wb_data  <= w_exc_code;
          end
        end
        ST_DONE: begin
          if (i_flush || i_wb_ready) begin
            r_state    <= ST_IDLE;
            r_wb_valid <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_issue_ready   = (r_state == ST_IDLE);
  assign o_stall         = (r_state != ST_IDLE);
  assign o_busy_rd       = r_rd;
  assign o_busy_rd_valid = (r_state != ST_IDLE) && !r_exc;
  assign o_md_operandA   = r_op_a;
  assign o_md_operandB   = r_op_b;
  assign o_md_ctrl_MULT  = r_ctrl_mult;
  assign o_md_ctrl_DIV   = r_ctrl_div;
  assign o_wb_valid      = r_wb_valid;
  assign o_wb_rd         = r_wb_rd;
  assign o_wb_data       = r_wb_data;

endmodule

`default_nettype wire

// File: tb/tb_multdiv_issue_ctrl.sv
// ============================================================================
// Module      : tb_multdiv_issue_ctrl
// Description : Directed and randomized self-checking bench for the multdiv
//               issue controller, with a behavioural multdiv model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multdiv_issue_ctrl;

  localparam int TMO = 40;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_issue_valid = 1'b0;
  logic        i_issue_mult = 1'b0;
  logic        i_issue_div = 1'b0;
  logic [31:0] i_issue_a = '0;
  logic [31:0] i_issue_b = '0;
  logic [4:0]  i_issue_rd = '0;
  logic        i_flush = 1'b0;
  logic [31:0] i_md_result = '0;
  logic        i_md_exception = 1'b0;
  logic        i_md_resultRDY = 1'b0;
  logic        i_wb_ready = 1'b0;
  logic        o_issue_ready;
  logic [31:0] o_md_operandA;
  logic [31:0] o_md_operandB;
  logic        o_md_ctrl_MULT;
  logic        o_md_ctrl_DIV;
  logic        o_stall;
  logic [4:0]  o_busy_rd;
  logic        o_busy_rd_valid;
  logic        o_wb_valid;
  logic [4:0]  o_wb_rd;
  logic [31:0] o_wb_data;

  int n_checks = 0;
  int n_err    = 0;

  multdiv_issue_ctrl dut (
    .i_clk           (i_clk),
    .i_rst_n         (i_rst_n),
    .i_issue_valid   (i_issue_valid),
    .i_issue_mult    (i_issue_mult),
    .i_issue_div     (i_issue_div),
    .i_issue_a       (i_issue_a),
    .i_issue_b       (i_issue_b),
    .i_issue_rd      (i_issue_rd),
    .o_issue_ready   (o_issue_ready),
    .i_flush         (i_flush),
    .o_md_operandA   (o_md_operandA),
    .o_md_operandB   (o_md_operandB),
    .o_md_ctrl_MULT  (o_md_ctrl_MULT),
    .o_md_ctrl_DIV   (o_md_ctrl_DIV),
    .i_md_result     (i_md_result),
    .i_md_exception  (i_md_exception),
    .i_md_resultRDY  (i_md_resultRDY),
    .o_stall         (o_stall),
    .o_busy_rd       (o_busy_rd),
    .o_busy_rd_valid (o_busy_rd_valid),
    .o_wb_valid      (o_wb_valid),
    .i_wb_ready      (i_wb_ready),
    .o_wb_rd         (o_wb_rd),
    .o_wb_data       (o_wb_data)
  );

  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // What an ideal multdiv unit would return (unsigned, low 32 bits).
  function automatic logic [31:0] md_model(input bit m, input logic [31:0] a, input logic [31:0] b);
    if (m) return a * b;
    if (b == 0) return 32'hFFFF_FFFF;
    return a / b;
  endfunction

  task automatic chk_idle(input string tag);
    chk({tag, "_ready"}, {31'd0, o_issue_ready}, 32'd1);
    chk({tag, "_stall"}, {31'd0, o_stall}, 32'd0);
    chk({tag, "_wbv"}, {31'd0, o_wb_valid}, 32'd0);
    chk({tag, "_pulse"}, {30'd0, o_md_ctrl_MULT, o_md_ctrl_DIV}, 32'd0);
  endtask

  // Issues one op; returns with the DUT in START.
  task automatic start_op(input bit m, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    chk("pre_ready", {31'd0, o_issue_ready}, 32'd1);
    i_issue_valid = 1'b1; i_issue_mult = m; i_issue_div = !m;
    i_issue_a = a; i_issue_b = b; i_issue_rd = rd;
    tick();
    i_issue_valid = 1'b0;
    i_issue_a = $urandom; i_issue_b = $urandom; i_issue_rd = 5'($urandom);
    chk("start_mult", {31'd0, o_md_ctrl_MULT}, {31'd0, m});
    chk("start_div", {31'd0, o_md_ctrl_DIV}, {31'd0, !m});
    chk("start_stall", {31'd0, o_stall}, 32'd1);
    chk("start_ready", {31'd0, o_issue_ready}, 32'd0);
    chk("start_opA", o_md_operandA, a);
    chk("start_opB", o_md_operandB, b);
    chk("start_busy_rd", {27'd0, o_busy_rd}, {27'd0, rd});
    chk("start_busy_rd_valid", {31'd0, o_busy_rd_valid}, 32'd1);
  endtask

  // Full op: RDY in BUSY cycle lat (lat>TMO means never), then writeback.
  task automatic run_op(input bit m, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                        input int lat, input bit exc, input bit stale, input int wbdel);
    bit          tmo;
    bit          exc_eff;
    int          n;
    logic [4:0]  exp_rd;
    logic [31:0] exp_data;
    start_op(m, a, b, rd);
    if (stale) begin
      i_md_resultRDY = 1'b1; i_md_result = $urandom; i_md_exception = 1'($urandom_range(0, 1));
    end
    tick();
    i_md_resultRDY = 1'b0; i_md_exception = 1'b0;
    tmo = (lat > TMO);
    n = tmo ? TMO : lat;
    for (int i = 1; i <= n; i++) begin
      chk("busy_wbv", {31'd0, o_wb_valid}, 32'd0);
      chk("busy_stall", {31'd0, o_stall}, 32'd1);
      chk("busy_pulse", {30'd0, o_md_ctrl_MULT, o_md_ctrl_DIV}, 32'd0);
      chk("busy_opA", o_md_operandA, a);
      if (i == n && !tmo) begin
        i_md_resultRDY = 1'b1; i_md_exception = exc;
        i_md_result = exc ? $urandom : md_model(m, a, b);
      end
      tick();
      i_md_resultRDY = 1'b0; i_md_exception = 1'b0; i_md_result = $urandom;
    end
    exc_eff  = tmo || exc;
    exp_rd   = exc_eff ? 5'd30 : rd;
    exp_data = exc_eff ? (m ? 32'd4 : 32'd5) : md_model(m, a, b);
    chk("done_busy_rd_valid", {31'd0, o_busy_rd_valid}, {31'd0, !exc_eff});
    // Competing issue during DONE must wait until after the handshake.
    i_issue_valid = 1'b1; i_issue_mult = 1'b1; i_issue_div = 1'b0;
    for (int k = 0; k <= wbdel; k++) begin
      chk("done_wbv", {31'd0, o_wb_valid}, 32'd1);
      chk("done_wb_rd", {27'd0, o_wb_rd}, {27'd0, exp_rd});
      chk("done_wb_data", o_wb_data, exp_data);
      chk("done_stall", {31'd0, o_stall}, 32'd1);
      chk("done_ready", {31'd0, o_issue_ready}, 32'd0);
      if (k < wbdel) tick();
    end
    i_wb_ready = 1'b1;
    tick();
    i_wb_ready = 1'b0; i_issue_valid = 1'b0;
    chk_idle("post_hs");
  endtask

  initial begin
    // Reset values
    #3;
    chk_idle("rst");
    chk("rst_opA", o_md_operandA, 32'd0);
    chk("rst_wb_data", o_wb_data, 32'd0);
    chk("rst_busy_rd_valid", {31'd0, o_busy_rd_valid}, 32'd0);
    tick(); tick();
    i_rst_n = 1'b1;
    tick();

    // Directed scenarios
    run_op(1'b1, 32'd7, 32'd6, 5'd5, 17, 1'b0, 1'b0, 0);
    run_op(1'b0, 32'd100, 32'd7, 5'd9, 3, 1'b0, 1'b1, 0);
    run_op(1'b0, 32'd55, 32'd0, 5'd12, 4, 1'b1, 1'b0, 1);
    run_op(1'b1, 32'h8000_0000, 32'd4, 5'd3, 6, 1'b1, 1'b0, 0);
    run_op(1'b1, 32'd11, 32'd13, 5'd0, 2, 1'b0, 1'b0, 5);
    run_op(1'b1, 32'd1, 32'd2, 5'd8, 99, 1'b0, 1'b0, 0);
    run_op(1'b0, 32'd9, 32'd3, 5'd8, 99, 1'b0, 1'b0, 2);
    run_op(1'b0, 32'd81, 32'd9, 5'd17, TMO, 1'b0, 1'b0, 0);

    // Neither op bit: nothing accepted
    i_issue_valid = 1'b1; i_issue_mult = 1'b0; i_issue_div = 1'b0;
    tick();
    i_issue_valid = 1'b0;
    chk_idle("no_op");

    // Both op bits: MULT wins
    i_issue_mult = 1'b1; i_issue_div = 1'b1; i_issue_valid = 1'b1;
    i_issue_a = 32'd3; i_issue_b = 32'd5; i_issue_rd = 5'd2;
    tick();
    i_issue_valid = 1'b0; i_issue_div = 1'b0;
    chk("both_mult", {31'd0, o_md_ctrl_MULT}, 32'd1);
    chk("both_div", {31'd0, o_md_ctrl_DIV}, 32'd0);
    i_flush = 1'b1;
    tick();
    i_flush = 1'b0;
    chk_idle("flush_start");

    // Flush in IDLE blocks a simultaneous issue
    i_flush = 1'b1; i_issue_valid = 1'b1; i_issue_mult = 1'b1;
    tick();
    i_flush = 1'b0; i_issue_valid = 1'b0;
    chk_idle("flush_idle");

    // Flush in BUSY; a later RDY is ignored
    start_op(1'b0, 32'd40, 32'd8, 5'd21);
    tick(); tick(); tick();
    i_flush = 1'b1;
    tick();
    i_flush = 1'b0;
    chk_idle("flush_busy");
    chk("flush_busy_rd_valid", {31'd0, o_busy_rd_valid}, 32'd0);
    i_md_resultRDY = 1'b1; i_md_result = 32'd5;
    tick();
    i_md_resultRDY = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk_idle("flush_late_rdy");
      tick();
    end

    // Flush in DONE drops wb_valid without handshake
    start_op(1'b1, 32'd6, 32'd6, 5'd4);
    tick();
    i_md_resultRDY = 1'b1; i_md_result = 32'd36;
    tick();
    i_md_resultRDY = 1'b0;
    chk("pre_flush_done_wbv", {31'd0, o_wb_valid}, 32'd1);
    i_flush = 1'b1;
    tick();
    i_flush = 1'b0;
    chk_idle("flush_done");

    // Asynchronous reset mid-BUSY
    start_op(1'b1, 32'd3, 32'd4, 5'd7);
    tick(); tick(); tick();
    #2 i_rst_n = 1'b0;
    #1;
    chk_idle("arst");
    chk("arst_opA", o_md_operandA, 32'd0);
    chk("arst_opB", o_md_operandB, 32'd0);
    chk("arst_busy_rd", {27'd0, o_busy_rd}, 32'd0);
    chk("arst_busy_rd_valid", {31'd0, o_busy_rd_valid}, 32'd0);
    chk("arst_wb_rd", {27'd0, o_wb_rd}, 32'd0);
    chk("arst_wb_data", o_wb_data, 32'd0);
    tick();
    i_rst_n = 1'b1;
    i_md_resultRDY = 1'b1; i_md_result = 32'd12;
    tick();
    i_md_resultRDY = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk_idle("arst_after");
      tick();
    end

    // Randomized ops against the model
    for (int t = 0; t < 16; t++) begin
      bit          rm;
      logic [31:0] ra;
      logic [31:0] rb;
      rm = 1'($urandom_range(0, 1));
      ra = $urandom;
      rb = $urandom_range(0, 3) == 0 ? 32'($urandom_range(0, 9)) : $urandom;
      run_op(rm, ra, rb, 5'($urandom), $urandom_range(1, 45),
             $urandom_range(0, 4) == 0, 1'($urandom_range(0, 1)), $urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
